// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//   Shares one main-memory block port between the L1 I-cache and L1 D-cache.
//   One requester is granted per transaction. The grant is held until memory
//   signals ready, followed by one RELEASE cycle. Ties are resolved
//   round-robin, and the D-cache wins the first tie after reset.
//   Saturating per-requester grant counters are provided.
// Ports
//   clk_i, rst_ni                 clock, synchronous active-low reset
//   ins_* / dat_*                 cache request (valid, wen, addr, wdata),
//                                 ready and read block back to each cache
//   mem_*                         memory request out, ready/read block in
//   busy_o                        a grant is active
//   gnt_cnt_ins_o/gnt_cnt_dat_o   saturating grant counts
module mem_port_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int BLOCK_W = 128,
  parameter int CNT_W   = 16
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               ins_valid_i,
  input  logic               ins_wen_i,
  input  logic [ADDR_W-1:0]  ins_addr_i,
  input  logic [BLOCK_W-1:0] ins_wdata_i,
  output logic               ins_ready_o,
  output logic [BLOCK_W-1:0] ins_rdata_o,
  input  logic               dat_valid_i,
  input  logic               dat_wen_i,
  input  logic [ADDR_W-1:0]  dat_addr_i,
  input  logic [BLOCK_W-1:0] dat_wdata_i,
  output logic               dat_ready_o,
  output logic [BLOCK_W-1:0] dat_rdata_o,
  output logic               mem_valid_o,
  output logic               mem_wen_o,
  output logic [ADDR_W-1:0]  mem_addr_o,
  output logic [BLOCK_W-1:0] mem_wdata_o,
  input  logic               mem_ready_i,
  input  logic [BLOCK_W-1:0] mem_rdata_i,
  output logic               busy_o,
  output logic [CNT_W-1:0]   gnt_cnt_ins_o,
  output logic [CNT_W-1:0]   gnt_cnt_dat_o
);

  typedef enum logic [1:0] {IDLE, GNT_INS, GNT_DAT, RELEASE} state_e;

  typedef struct packed {
    logic               wen;
    logic [ADDR_W-1:0]  addr;
    logic [BLOCK_W-1:0] wdata;
  } req_t;

  state_e           state_q, state_d;
  logic             last_dat_q;  // 1: D-cache was served last, 0: I-cache
  logic [CNT_W-1:0] cnt_ins_q, cnt_dat_q;
  req_t             ins_req, dat_req, mem_req;

  assign ins_req = '{wen: ins_wen_i, addr: ins_addr_i, wdata: ins_wdata_i};
  assign dat_req = '{wen: dat_wen_i, addr: dat_addr_i, wdata: dat_wdata_i};

  // The IDLE decision uses only the request valids and last_dat_q.
  // mem_ready_i only affects the exit from a grant state.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (ins_valid_i && dat_valid_i) state_d = last_dat_q ? GNT_INS : GNT_DAT;
        else if (dat_valid_i)           state_d = GNT_DAT;
        else if (ins_valid_i)           state_d = GNT_INS;
      end
      GNT_INS: if (mem_ready_i) state_d = RELEASE;
      GNT_DAT: if (mem_ready_i) state_d = RELEASE;
      RELEASE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q    <= IDLE;
      last_dat_q <= 1'b0;
      cnt_ins_q  <= '0;
      cnt_dat_q  <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == IDLE && state_d == GNT_INS) begin
        last_dat_q <= 1'b0;
        if (cnt_ins_q != '1) cnt_ins_q <= cnt_ins_q + 1'b1;
      end
      if (state_q == IDLE && state_d == GNT_DAT) begin
        last_dat_q <= 1'b1;
        if (cnt_dat_q != '1) cnt_dat_q <= cnt_dat_q + 1'b1;
      end
    end
  end

  // The memory request follows the granted cache's live inputs. It is zero outside a grant.
  always_comb begin
    mem_req     = '0;
    mem_valid_o = 1'b0;
    ins_ready_o = 1'b0;
    dat_ready_o = 1'b0;
    unique case (state_q)
      GNT_INS: begin
        mem_req     = ins_req;
        mem_valid_o = 1'b1;
        ins_ready_o = mem_ready_i;
      end
      GNT_DAT: begin
        mem_req     = dat_req;
        mem_valid_o = 1'b1;
        dat_ready_o = mem_ready_i;
      end
      default: ;
    endcase
  end

  assign mem_wen_o     = mem_req.wen;
  assign mem_addr_o    = mem_req.addr;
  assign mem_wdata_o   = mem_req.wdata;
  assign busy_o        = mem_valid_o;
  assign ins_rdata_o   = mem_rdata_i;
  assign dat_rdata_o   = mem_rdata_i;
  assign gnt_cnt_ins_o = cnt_ins_q;
  assign gnt_cnt_dat_o = cnt_dat_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
module tb_mem_port_arbiter;
  localparam int AW   = 32;
  localparam int BW   = 128;
  localparam int CW   = 4;
  localparam int CMAX = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          rst_ni;
  logic          ins_valid_i, ins_wen_i, dat_valid_i, dat_wen_i;
  logic [AW-1:0] ins_addr_i, dat_addr_i;
  logic [BW-1:0] ins_wdata_i, dat_wdata_i;
  logic          ins_ready_o, dat_ready_o;
  logic [BW-1:0] ins_rdata_o, dat_rdata_o;
  logic          mem_valid_o, mem_wen_o, mem_ready_i, busy_o;
  logic [AW-1:0] mem_addr_o;
  logic [BW-1:0] mem_wdata_o, mem_rdata_i;
  logic [CW-1:0] gnt_cnt_ins_o, gnt_cnt_dat_o;

  always #5 clk = ~clk;

  mem_port_arbiter #(.ADDR_W(AW), .BLOCK_W(BW), .CNT_W(CW)) dut (
    .clk_i(clk), .rst_ni(rst_ni),
    .ins_valid_i(ins_valid_i), .ins_wen_i(ins_wen_i), .ins_addr_i(ins_addr_i),
    .ins_wdata_i(ins_wdata_i), .ins_ready_o(ins_ready_o), .ins_rdata_o(ins_rdata_o),
    .dat_valid_i(dat_valid_i), .dat_wen_i(dat_wen_i), .dat_addr_i(dat_addr_i),
    .dat_wdata_i(dat_wdata_i), .dat_ready_o(dat_ready_o), .dat_rdata_o(dat_rdata_o),
    .mem_valid_o(mem_valid_o), .mem_wen_o(mem_wen_o), .mem_addr_o(mem_addr_o),
    .mem_wdata_o(mem_wdata_o), .mem_ready_i(mem_ready_i), .mem_rdata_i(mem_rdata_i),
    .busy_o(busy_o), .gnt_cnt_ins_o(gnt_cnt_ins_o), .gnt_cnt_dat_o(gnt_cnt_dat_o)
  );

  int tests = 0;
  int fails = 0;

  // Reference model at transaction level: who was served last, and the grant counts.
  bit m_last_dat;
  int m_ci, m_cd;

  task automatic chk(input string tag, input logic [BW-1:0] obs, input logic [BW-1:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Inputs are driven 1 time unit after posedge. Outputs are checked at negedge.
  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst_ni = 1'b0;
    ins_valid_i = 0; dat_valid_i = 0; mem_ready_i = 0;
    step(); step();
    rst_ni = 1'b1;
    m_last_dat = 0; m_ci = 0; m_cd = 0;
  endtask

  // Call this in an IDLE cycle, with requests already driven.
  // It returns at the negedge of the following IDLE cycle.
  // lat:   grant cycle (1-based) in which memory pulses ready.
  // keep:  the served cache keeps valid high after RELEASE.
  // raise: the other cache raises valid in grant cycle 2.
  task automatic do_txn(input int lat, input bit keep, input bit raise);
    bit            w_dat;
    logic [BW-1:0] rd;
    rd = '0;
    w_dat = (ins_valid_i && dat_valid_i) ? !m_last_dat : dat_valid_i;
    m_last_dat = w_dat;
    if (w_dat) m_cd = (m_cd < CMAX) ? m_cd + 1 : CMAX;
    else       m_ci = (m_ci < CMAX) ? m_ci + 1 : CMAX;
    step();
    for (int c = 1; c <= lat; c++) begin
      if (c == 2 && raise) begin
        if (w_dat) ins_valid_i = 1'b1; else dat_valid_i = 1'b1;
      end
      if (c == lat) begin
        rd = {$urandom, $urandom, $urandom, $urandom};
        mem_rdata_i = rd;
        mem_ready_i = 1'b1;
      end
      smp();
      chk("gnt_valid", mem_valid_o, 1'b1);
      chk("gnt_busy", busy_o, 1'b1);
      chk("gnt_addr", mem_addr_o, w_dat ? dat_addr_i : ins_addr_i);
      chk("gnt_wen", mem_wen_o, w_dat ? dat_wen_i : ins_wen_i);
      chk("gnt_wdata", mem_wdata_o, w_dat ? dat_wdata_i : ins_wdata_i);
      chk("ins_ready", ins_ready_o, !w_dat && c == lat);
      chk("dat_ready", dat_ready_o, w_dat && c == lat);
      if (c == lat) chk("rdata", w_dat ? dat_rdata_o : ins_rdata_o, rd);
      if (c == 1) begin
        chk("cnt_ins", gnt_cnt_ins_o, m_ci);
        chk("cnt_dat", gnt_cnt_dat_o, m_cd);
      end
      step();
    end
    mem_ready_i = 1'b0;
    if (!keep) begin
      if (w_dat) dat_valid_i = 1'b0; else ins_valid_i = 1'b0;
    end
    smp();
    chk("rel_valid", mem_valid_o, 1'b0);
    chk("rel_busy", busy_o, 1'b0);
    step();
    smp();
    chk("idle_valid", mem_valid_o, 1'b0);
    chk("idle_busy", busy_o, 1'b0);
  endtask

  task automatic set_req(input bit iv, input bit dv);
    ins_valid_i = iv; dat_valid_i = dv;
    ins_wen_i = 1'($urandom); dat_wen_i = 1'($urandom);
    ins_addr_i = $urandom; dat_addr_i = $urandom | 32'h1;
    ins_addr_i[0] = 1'b0;  // addresses never collide, so mem_addr_o shows who was granted
    ins_wdata_i = {$urandom, $urandom, $urandom, $urandom};
    dat_wdata_i = {$urandom, $urandom, $urandom, $urandom};
  endtask

  initial begin
    ins_wen_i = 0; dat_wen_i = 0; ins_addr_i = 0; dat_addr_i = 0;
    ins_wdata_i = 0; dat_wdata_i = 0; mem_rdata_i = 0;
    do_reset();
    smp();
    chk("rst_valid", mem_valid_o, 1'b0);
    chk("rst_busy", busy_o, 1'b0);
    chk("rst_cnt_ins", gnt_cnt_ins_o, 0);
    chk("rst_cnt_dat", gnt_cnt_dat_o, 0);

    // Single D-cache read at 0x40.
    set_req(0, 1); dat_wen_i = 0; dat_addr_i = 32'h0000_0040;
    do_txn(3, 0, 0);
    chk("t1_cnt_dat", gnt_cnt_dat_o, 1);

    // First tie after reset goes to the D-cache, then the I-cache.
    do_reset();
    set_req(1, 1);
    do_txn(2, 0, 0);
    do_txn(2, 0, 0);
    chk("t2_cnt_ins", gnt_cnt_ins_o, 1);
    chk("t2_cnt_dat", gnt_cnt_dat_o, 1);

    // Both caches continuously valid: grants alternate, starting with D.
    set_req(1, 1);
    for (int i = 0; i < 6; i++) do_txn(1 + (i % 3), 1, 0);
    ins_valid_i = 0; dat_valid_i = 0;

    // D write with the I request raised mid-grant.
    set_req(0, 1); dat_wen_i = 1;
    dat_wdata_i = 128'hDEAD_BEEF_DEAD_BEEF_DEAD_BEEF_DEAD_BEEF;
    do_txn(3, 0, 1);
    do_txn(1, 0, 0);

    // Randomized traffic.
    for (int i = 0; i < 40; i++) begin
      int v;
      v = $urandom_range(1, 3);
      set_req(v[0], v[1]);
      do_txn($urandom_range(1, 4), 1'($urandom), 1'($urandom));
      ins_valid_i = 0; dat_valid_i = 0;
    end

    // Reset in the 2nd cycle of GNT_INS. A later ready must not be forwarded.
    set_req(1, 0);
    step();
    smp();
    chk("pre_rst_valid", mem_valid_o, 1'b1);
    step();
    rst_ni = 1'b0;
    step();
    rst_ni = 1'b1; ins_valid_i = 0;
    m_last_dat = 0; m_ci = 0; m_cd = 0;
    smp();
    chk("mid_rst_valid", mem_valid_o, 1'b0);
    chk("mid_rst_busy", busy_o, 1'b0);
    chk("mid_rst_cnt_ins", gnt_cnt_ins_o, 0);
    chk("mid_rst_cnt_dat", gnt_cnt_dat_o, 0);
    step();
    mem_ready_i = 1'b1;
    smp();
    chk("stray_ins_ready", ins_ready_o, 1'b0);
    chk("stray_dat_ready", dat_ready_o, 1'b0);
    step();
    mem_ready_i = 1'b0;

    // Counter saturation: 16 D grants on a 4-bit counter.
    for (int i = 0; i < CMAX + 1; i++) begin
      set_req(0, 1);
      do_txn(1, 0, 0);
    end
    chk("sat_cnt_dat", gnt_cnt_dat_o, CMAX);
    chk("sat_cnt_ins", gnt_cnt_ins_o, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
